// File: rtl/ram_arbiter_2p.sv
// -----------------------------------------------------------------------------
// ram_arbiter_2p
//
// Purpose:
//   Arbitrates two independent masters onto one small synchronous RAM port.
//   One transaction is in flight at a time. Each transaction walks a fixed
//   four-state sequence: IDLE -> GRANT -> RESP -> DONE -> IDLE.
//   When both masters request at once, a one-bit round-robin pointer decides
//   the winner.
//
// Parameters:
//   AW  address width (RAM depth = 2**AW)
//   DW  data width
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   req0/req1           request from master 0 / 1
//   we0/we1             1 = write, 0 = read (valid while reqN is high)
//   addr0/addr1         access address
//   wdata0/wdata1       write data
//   gnt0/gnt1           high during the RAM access cycle of that master
//   done0/done1         one-cycle completion pulse
//   rdata0/rdata1       read result, held until that master's next read
//   mem_we              RAM write enable
//   mem_addr            RAM address
//   mem_wdata           RAM write data
//   mem_rdata           RAM read data (registered, valid one cycle after addr)
// -----------------------------------------------------------------------------
module ram_arbiter_2p #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_RESP  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // ---------------------------------------------------------------------------
  // Per-master views of the request inputs, indexed by master number
  // ---------------------------------------------------------------------------
  logic [1:0]    req_vec;
  logic [1:0]    we_vec;
  logic [AW-1:0] addr_arr  [2];
  logic [DW-1:0] wdata_arr [2];

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // master that owns the current transaction
  logic          ptr_q,   ptr_d;     // master favoured on the next contention
  logic          we_q,    we_d;      // latched transaction attributes
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q [2];

  // ---------------------------------------------------------------------------
  // Arbitration: a lone request always wins; on contention the pointer picks.
  // ---------------------------------------------------------------------------
  logic any_req;
  logic winner;

  always_comb begin
    any_req = |req_vec;
    winner  = 1'b0;
    if (req_vec == 2'b11) begin
      winner = ptr_q;
    end else begin
      winner = req_vec[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          owner_d = winner;
          // The master just served loses the next tie.
          ptr_d   = ~winner;
          we_d    = we_vec[winner];
          addr_d  = addr_arr[winner];
          wdata_d = wdata_arr[winner];
        end
      end
      ST_GRANT: state_d = ST_RESP;
      ST_RESP:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-master read-data capture and grant/done decode
  // ---------------------------------------------------------------------------
  logic [1:0] gnt_vec;
  logic [1:0] done_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    // The RAM output is valid during RESP (address was presented in GRANT),
    // so the owner's read result is captured on the edge that leaves RESP.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q[gi] <= '0;
      end else if ((state_q == ST_RESP) && !we_q && (owner_q == 1'(gi))) begin
        rdata_q[gi] <= mem_rdata;
      end
    end

    assign gnt_vec[gi]  = (state_q == ST_GRANT) && (owner_q == 1'(gi));
    assign done_vec[gi] = (state_q == ST_DONE)  && (owner_q == 1'(gi));
  end

  assign gnt0   = gnt_vec[0];
  assign gnt1   = gnt_vec[1];
  assign done0  = done_vec[0];
  assign done1  = done_vec[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

  // ---------------------------------------------------------------------------
  // RAM port. The address/data are held through RESP and zeroed elsewhere.
  // The write enable is also masked by rst so that a reset landing on a
  // GRANT cycle aborts the write instead of committing it.
  // ---------------------------------------------------------------------------
  logic mem_active;

  assign mem_active = (state_q == ST_GRANT) || (state_q == ST_RESP);
  assign mem_we     = (state_q == ST_GRANT) && we_q && !rst;
  assign mem_addr   = mem_active ? addr_q  : '0;
  assign mem_wdata  = mem_active ? wdata_q : '0;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
module tb_ram_arbiter_2p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [1:0][1:0] addr;
  logic [1:0][7:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [1:0][7:0] rdata;
  logic            mem_we;
  logic [1:0]      mem_addr;
  logic [7:0]      mem_wdata;
  logic [7:0]      mem_rdata = 8'h00;

  // Bench RAM: synchronous write, registered read, contents start at zero.
  logic [7:0] ram [4] = '{default: 8'h00};

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  ram_arbiter_2p #(.AW(2), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req[0]),
    .req1      (req[1]),
    .we0       (we[0]),
    .we1       (we[1]),
    .addr0     (addr[0]),
    .addr1     (addr[1]),
    .wdata0    (wdata[0]),
    .wdata1    (wdata[1]),
    .gnt0      (gnt[0]),
    .gnt1      (gnt[1]),
    .done0     (done[0]),
    .done1     (done[1]),
    .rdata0    (rdata[0]),
    .rdata1    (rdata[1]),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_rd [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from master m. Called at an IDLE negedge;
  // returns at the IDLE negedge following the done pulse.
  task automatic run_txn(input int m, input logic w, input logic [1:0] a,
                         input logic [7:0] d, input logic [7:0] e);
    int o;
    bit seen;
    o = 1 - m;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      seen = gnt[m];
    end
    if (!seen) begin
      check_eq("gnt_timeout", 32'd0, 32'd1);
      req[m] = 1'b0;
      return;
    end
    check_eq("grant_other", gnt[o], 0);
    check_eq("grant_we", mem_we, w);
    check_eq("grant_addr", mem_addr, a);
    check_eq("grant_wdata", mem_wdata, d);
    @(negedge clk);
    check_eq("resp_we", mem_we, 0);
    check_eq("resp_addr", mem_addr, a);
    check_eq("resp_gnt", gnt, 0);
    check_eq("resp_done", done, 0);
    @(negedge clk);
    check_eq("done_own", done[m], 1);
    check_eq("done_other", done[o], 0);
    if (!w) exp_rd[m] = e;
    check_eq("rdata_own", rdata[m], exp_rd[m]);
    check_eq("rdata_hold", rdata[o], exp_rd[o]);
    req[m] = 1'b0;
    $display("[TB] txn m%0d %s addr=%0d wdata=0x%02h rdata=0x%02h", m, w ? "WR" : "RD",
             a, d, rdata[m]);
    @(negedge clk);
    check_eq("idle_done", done, 0);
    check_eq("idle_gnt", gnt, 0);
    check_eq("idle_mem_we", mem_we, 0);
  endtask

  // Both masters read continuously; grants must alternate starting at master 0.
  task automatic run_contend(input int n, input logic [1:0] a0, input logic [1:0] a1,
                             input logic [7:0] e0, input logic [7:0] e1);
    int m;
    int o;
    req = 2'b11; we = 2'b00;
    addr[0] = a0; addr[1] = a1;
    wdata[0] = 8'h00; wdata[1] = 8'h00;
    for (int k = 0; k < n; k++) begin
      m = k % 2;
      o = 1 - m;
      @(negedge clk);
      check_eq("rr_gnt_own", gnt[m], 1);
      check_eq("rr_gnt_other", gnt[o], 0);
      check_eq("rr_grant_done", done, 0);
      check_eq("rr_addr", mem_addr, (m == 0) ? a0 : a1);
      @(negedge clk);
      @(negedge clk);
      check_eq("rr_done_own", done[m], 1);
      check_eq("rr_done_other", done[o], 0);
      exp_rd[m] = (m == 0) ? e0 : e1;
      check_eq("rr_rdata", rdata[m], exp_rd[m]);
      if (k == n - 1) req = 2'b00;
      $display("[TB] txn contend #%0d m%0d RD rdata=0x%02h", k, m, rdata[m]);
      @(negedge clk);
      check_eq("rr_idle_gnt", gnt, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] dat;
    int wm;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rdata0", rdata[0], 0);
    check_eq("rst_rdata1", rdata[1], 0);
    rst = 1'b0;

    // Master 0 write, then master 1 read back
    run_txn(0, 1'b1, 2'd2, 8'hA5, 8'h00);
    run_txn(1, 1'b0, 2'd2, 8'h00, 8'hA5);

    // Sustained contention: order 0,1,0,1
    run_contend(4, 2'd2, 2'd0, 8'hA5, 8'h00);

    // Master 1 requests during master 0's GRANT and must wait
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 2'd1; wdata[0] = 8'h3C;
    @(negedge clk);
    check_eq("mid_gnt0", gnt[0], 1);
    check_eq("mid_we", mem_we, 1);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 2'd1; wdata[1] = 8'h00;
    @(negedge clk);
    check_eq("mid_resp_gnt1", gnt[1], 0);
    @(negedge clk);
    check_eq("mid_done0", done[0], 1);
    check_eq("mid_done_gnt1", gnt[1], 0);
    req[0] = 1'b0;
    $display("[TB] txn m0 WR addr=1 wdata=0x3c (m1 pending)");
    @(negedge clk);
    check_eq("mid_idle_gnt", gnt, 0);
    @(negedge clk);
    check_eq("mid_gnt1", gnt[1], 1);
    check_eq("mid_gnt1_we", mem_we, 0);
    check_eq("mid_gnt1_addr", mem_addr, 1);
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_done1", done[1], 1);
    exp_rd[1] = 8'h3C;
    check_eq("mid_rdata1", rdata[1], 8'h3C);
    check_eq("mid_rdata0_hold", rdata[0], exp_rd[0]);
    req[1] = 1'b0;
    $display("[TB] txn m1 RD addr=1 rdata=0x%02h", rdata[1]);
    @(negedge clk);

    // Reset lands on the GRANT cycle of a write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 2'd3; wdata[0] = 8'hFF;
    @(negedge clk);
    check_eq("abort_gnt0", gnt[0], 1);
    check_eq("abort_we_pre", mem_we, 1);
    rst = 1'b1; req[0] = 1'b0;
    #1;
    check_eq("abort_we_rst", mem_we, 0);
    @(negedge clk);
    check_eq("abort_gnt", gnt, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_mem_we", mem_we, 0);
    check_eq("abort_mem_addr", mem_addr, 0);
    check_eq("abort_mem_wdata", mem_wdata, 0);
    check_eq("abort_rdata0", rdata[0], 0);
    check_eq("abort_rdata1", rdata[1], 0);
    $display("[TB] txn m0 WR addr=3 wdata=0xff aborted by reset");
    rst = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;

    // First contention after reset goes to master 0; addr 3 was never written
    run_contend(2, 2'd2, 2'd3, 8'hA5, 8'h00);

    // Alternating write/read across all addresses
    for (int i = 0; i < 4; i++) begin
      dat = 8'(8'h11 * (i + 1));
      wm  = i % 2;
      run_txn(wm, 1'b1, 2'(i), dat, 8'h00);
      run_txn(1 - wm, 1'b0, 2'(i), 8'h00, dat);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
